// File: rtl/updi_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : updi_uart_tx_if
// Description : Byte handshake between a UPDI transmit client and the
//               updi_uart_tx serialiser (data, valid/ready, break request).
// Revision    : 1.0 - initial release
// ============================================================================
interface updi_uart_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       send_break;

  // Client side: offers bytes and break requests.
  modport master (
    output data_in,
    output data_valid,
    output send_break,
    input  data_ready
  );

  // Serialiser side: consumes bytes, reports idle.
  modport slave (
    input  data_in,
    input  data_valid,
    input  send_break,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/updi_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : updi_uart_tx
// Description : UPDI frame serialiser. Sends 1 start, 8 data (LSB first),
//               even parity and STOP_BITS stop bits, or a BREAK (line held
//               low for BREAK_BITS bit periods). Bit timing comes from the
//               one-cycle baud_tick strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module updi_uart_tx #(
  parameter int STOP_BITS  = 2,
  parameter int BREAK_BITS = 12
) (
  input  wire            clk_in,
  input  wire            rst_n,
  input  wire            baud_tick,
  updi_uart_tx_if.slave  bus,
  output logic           tx_out,
  output logic           tx_oe,
  output logic           tx_done
);

  localparam logic [7:0] c_stop_bits  = 8'(STOP_BITS);
  localparam logic [7:0] c_break_bits = 8'(BREAK_BITS);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ARMED     = 4'd1,
    S_START     = 4'd2,
    S_DATA      = 4'd3,
    S_PARITY    = 4'd4,
    S_STOP      = 4'd5,
    S_BRK_ARMED = 4'd6,
    S_BREAK     = 4'd7
  } state_t;

  state_t     r_state,   w_state_nxt;
  logic [7:0] r_shift,   w_shift_nxt;
  logic       r_parity,  w_parity_nxt;
  logic [2:0] r_idx,     w_idx_nxt;
  logic [7:0] r_count,   w_count_nxt;
  logic       r_tx_out,  w_tx_out_nxt;
  logic       r_tx_oe,   w_tx_oe_nxt;
  logic       r_tx_done, w_tx_done_nxt;

  // Idle is the only state that can accept new work.
  assign bus.data_ready = (r_state == S_IDLE);
  assign tx_out         = r_tx_out;
  assign tx_oe          = r_tx_oe;
  assign tx_done        = r_tx_done;

  // State and datapath registers; reset drops the line driver immediately.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
      r_idx     <= 3'd0;
      r_count   <= 8'd0;
      r_tx_out  <= 1'b1;
      r_tx_oe   <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_idx     <= w_idx_nxt;
      r_count   <= w_count_nxt;
      r_tx_out  <= w_tx_out_nxt;
      r_tx_oe   <= w_tx_oe_nxt;
      r_tx_done <= w_tx_done_nxt;
    end
  end

  // Next-state and next-output decode; every bit change waits for a tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_idx_nxt     = r_idx;
    w_count_nxt   = r_count;
    w_tx_out_nxt  = r_tx_out;
    w_tx_oe_nxt   = r_tx_oe;
    w_tx_done_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A break request takes priority over a pending byte.
        if (bus.send_break) begin
          w_state_nxt = S_BRK_ARMED;
          w_tx_oe_nxt = 1'b1;
        end else if (bus.data_valid) begin
          w_shift_nxt  = bus.data_in;
          w_parity_nxt = ^bus.data_in;
          w_state_nxt  = S_ARMED;
          w_tx_oe_nxt  = 1'b1;
        end
      end
      S_ARMED: begin
        if (baud_tick) begin
          w_state_nxt  = S_START;
          w_tx_out_nxt = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          w_state_nxt  = S_DATA;
          w_tx_out_nxt = r_shift[0];
          w_shift_nxt  = r_shift >> 1;
          w_idx_nxt    = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (r_idx == 3'd7) begin
            w_state_nxt  = S_PARITY;
            w_tx_out_nxt = r_parity;
          end else begin
            w_tx_out_nxt = r_shift[0];
            w_shift_nxt  = r_shift >> 1;
            w_idx_nxt    = r_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          w_state_nxt  = S_STOP;
          w_tx_out_nxt = 1'b1;
          w_count_nxt  = 8'd1;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (r_count == c_stop_bits) begin
            w_state_nxt   = S_IDLE;
            w_tx_oe_nxt   = 1'b0;
            w_tx_done_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count + 8'd1;
          end
        end
      end
      S_BRK_ARMED: begin
        if (baud_tick) begin
          w_state_nxt  = S_BREAK;
          w_tx_out_nxt = 1'b0;
          w_count_nxt  = 8'd1;
        end
      end
      S_BREAK: begin
        if (baud_tick) begin
          if (r_count == c_break_bits) begin
            w_state_nxt   = S_IDLE;
            w_tx_out_nxt  = 1'b1;
            w_tx_oe_nxt   = 1'b0;
            w_tx_done_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_tx_out_nxt = 1'b1;
        w_tx_oe_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
